// File: rtl/avalon_master_arbiter.sv
// Round-robin share of one Avalon-MM master port between two requesters.
// Reads are tagged in a small FIFO so returning data is steered to its issuer.
module avalon_master_arbiter #(
  parameter int ADDRESSWIDTH = 26,
  parameter int DATAWIDTH    = 32,
  parameter int MAX_PENDING  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [ADDRESSWIDTH-1:0]       r0_address,
  input  logic [DATAWIDTH-1:0]          r0_writedata,
  input  logic                          r0_write,
  input  logic                          r0_read,
  output logic                          r0_waitrequest,
  output logic [DATAWIDTH-1:0]          r0_readdata,
  output logic                          r0_readdatavalid,
  input  logic [ADDRESSWIDTH-1:0]       r1_address,
  input  logic [DATAWIDTH-1:0]          r1_writedata,
  input  logic                          r1_write,
  input  logic                          r1_read,
  output logic                          r1_waitrequest,
  output logic [DATAWIDTH-1:0]          r1_readdata,
  output logic                          r1_readdatavalid,
  output logic [ADDRESSWIDTH-1:0]       master_address,
  output logic [DATAWIDTH-1:0]          master_writedata,
  output logic                          master_write,
  output logic                          master_read,
  input  logic [DATAWIDTH-1:0]          master_readdata,
  input  logic                          master_readdatavalid,
  input  logic                          master_waitrequest,
  output logic [$clog2(MAX_PENDING):0]  pending_count,
  output logic                          rsp_error
);

  localparam int PW = $clog2(MAX_PENDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_MAX_PENDING = CW'(MAX_PENDING);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]              r_state;
  logic                    r_last_grant;
  logic                    r_grant_id;
  logic [ADDRESSWIDTH-1:0] r_m_address;
  logic [DATAWIDTH-1:0]    r_m_writedata;
  logic                    r_m_write;
  logic                    r_m_read;
  logic [CW-1:0]           r_pending;
  logic                    r_rsp_error;
  logic                    r_tag_mem [MAX_PENDING];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [DATAWIDTH-1:0]    r_rdata [2];
  logic [1:0]              r_rvalid;

  logic [ADDRESSWIDTH-1:0] w_req_address [2];
  logic [DATAWIDTH-1:0]    w_req_writedata [2];
  logic [1:0]              w_req_write;
  logic [1:0]              w_req_read;
  logic [1:0]              w_eligible;
  logic [1:0]              w_grant_onehot;
  logic                    w_can_read;
  logic                    w_grant_id;
  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_head_tag;

  assign w_req_address[0]   = r0_address;
  assign w_req_address[1]   = r1_address;
  assign w_req_writedata[0] = r0_writedata;
  assign w_req_writedata[1] = r1_writedata;
  assign w_req_write        = {r1_write, r0_write};
  assign w_req_read         = {r1_read, r0_read};

  assign w_can_read = (r_pending < C_MAX_PENDING);
  // On a tie the requester that did not win last time goes next.
  assign w_grant_id = (&w_eligible) ? ~r_last_grant : w_eligible[1];
  assign w_accept   = reset_n && (r_state == S_IDLE) && (|w_eligible);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign w_eligible[gi]     = w_req_write[gi] | (w_req_read[gi] & w_can_read);
      assign w_grant_onehot[gi] = w_accept && (w_grant_id == 1'(gi));
    end
  endgenerate

  assign r0_waitrequest = ~w_grant_onehot[0];
  assign r1_waitrequest = ~w_grant_onehot[1];

  assign w_push     = (r_state == S_ISSUE) && r_m_read && !master_waitrequest;
  assign w_pop      = master_readdatavalid && (r_pending != '0);
  assign w_head_tag = r_tag_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= r_grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b1;
      r_grant_id    <= 1'b0;
      r_m_address   <= '0;
      r_m_writedata <= '0;
      r_m_write     <= 1'b0;
      r_m_read      <= 1'b0;
      r_pending     <= '0;
      r_rsp_error   <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_rvalid      <= 2'b00;
      r_rdata[0]    <= '0;
      r_rdata[1]    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_m_address   <= w_req_address[w_grant_id];
            r_m_writedata <= w_req_writedata[w_grant_id];
            r_m_write     <= w_req_write[w_grant_id];
            r_m_read      <= ~w_req_write[w_grant_id];
            r_last_grant  <= w_grant_id;
            r_grant_id    <= w_grant_id;
            r_state       <= S_ISSUE;
          end
        end
        default: begin
          if (!master_waitrequest) begin
            r_m_write <= 1'b0;
            r_m_read  <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
      endcase

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_pending <= r_pending + CW'(1);
        2'b01:   r_pending <= r_pending - CW'(1);
        default: ;
      endcase

      // A response with nothing outstanding is dropped and flagged.
      if (master_readdatavalid && (r_pending == '0)) begin
        r_rsp_error <= 1'b1;
      end

      for (int i = 0; i < 2; i++) begin
        r_rvalid[i] <= w_pop && (w_head_tag == 1'(i));
        if (w_pop && (w_head_tag == 1'(i))) begin
          r_rdata[i] <= master_readdata;
        end
      end
    end
  end

  assign master_address   = r_m_address;
  assign master_writedata = r_m_writedata;
  assign master_write     = r_m_write;
  assign master_read      = r_m_read;
  assign pending_count    = r_pending;
  assign rsp_error        = r_rsp_error;
  assign r0_readdata      = r_rdata[0];
  assign r1_readdata      = r_rdata[1];
  assign r0_readdatavalid = r_rvalid[0];
  assign r1_readdatavalid = r_rvalid[1];

endmodule

// File: tb/tb_avalon_master_arbiter.sv
// Directed bench for avalon_master_arbiter with a read-tag scoreboard.
module tb_avalon_master_arbiter;

  logic        clk;
  logic        reset_n;
  logic [25:0] r0_address, r1_address;
  logic [31:0] r0_writedata, r1_writedata;
  logic        r0_write, r0_read, r1_write, r1_read;
  logic        r0_waitrequest, r1_waitrequest;
  logic [31:0] r0_readdata, r1_readdata;
  logic        r0_readdatavalid, r1_readdatavalid;
  logic [25:0] master_address;
  logic [31:0] master_writedata;
  logic        master_write, master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid, master_waitrequest;
  logic [2:0]  pending_count;
  logic        rsp_error;

  avalon_master_arbiter #(.ADDRESSWIDTH(26), .DATAWIDTH(32), .MAX_PENDING(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_address(r0_address), .r0_writedata(r0_writedata), .r0_write(r0_write),
    .r0_read(r0_read), .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata),
    .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_writedata(r1_writedata), .r1_write(r1_write),
    .r1_read(r1_read), .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata),
    .r1_readdatavalid(r1_readdatavalid),
    .master_address(master_address), .master_writedata(master_writedata),
    .master_write(master_write), .master_read(master_read),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest),
    .pending_count(pending_count), .rsp_error(rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          rx0     = 0;
  int          rx1     = 0;
  int          ret_k   = 0;
  bit          auto_ret = 0;
  logic        cur_id  = 1'b0;
  logic        exp_tag_q [$];
  int          due_q [$];
  logic [31:0] dat_q [$];
  logic [1:0]  exp_rdv;
  logic [31:0] exp_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Checks both waitrequests against the requester the bench expects to win (-1 = none).
  task automatic expect_grant(input int id);
    #1;
    chk("r0_waitrequest", 64'(r0_waitrequest), (id == 0) ? 64'd0 : 64'd1);
    chk("r1_waitrequest", 64'(r1_waitrequest), (id == 1) ? 64'd0 : 64'd1);
    if (id >= 0) cur_id = (id == 1);
  endtask

  // One clock: drives bus responses, keeps the tag scoreboard, checks routed read data.
  task automatic step();
    logic t;
    exp_rdv = 2'b00;
    if (auto_ret && due_q.size() > 0 && due_q[0] <= cyc) begin
      due_q.delete(0);
      master_readdatavalid = 1'b1;
      master_readdata      = dat_q.pop_front();
    end
    if (!reset_n) begin
      exp_tag_q.delete();
      due_q.delete();
      dat_q.delete();
    end else begin
      if (master_readdatavalid && exp_tag_q.size() > 0) begin
        t = exp_tag_q.pop_front();
        exp_rdv[t] = 1'b1;
        exp_data   = master_readdata;
      end
      if (master_read && !master_waitrequest) begin
        exp_tag_q.push_back(cur_id);
        if (auto_ret) begin
          due_q.push_back(cyc + 3);
          dat_q.push_back(32'h1000 + 32'(ret_k));
          ret_k++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("r0_readdatavalid", 64'(r0_readdatavalid), 64'(exp_rdv[0]));
    chk("r1_readdatavalid", 64'(r1_readdatavalid), 64'(exp_rdv[1]));
    if (exp_rdv[0]) begin
      chk("r0_readdata", 64'(r0_readdata), 64'(exp_data));
      rx0++;
    end
    if (exp_rdv[1]) begin
      chk("r1_readdata", 64'(r1_readdata), 64'(exp_data));
      rx1++;
    end
    master_readdatavalid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    r0_address = '0; r0_writedata = '0; r0_write = 1'b0; r0_read = 1'b0;
    r1_address = '0; r1_writedata = '0; r1_write = 1'b0; r1_read = 1'b0;
    master_readdata = '0; master_readdatavalid = 1'b0; master_waitrequest = 1'b0;
    step();
    step();
    reset_n = 1'b1;

    // Reset state
    chk("rst_master_read", 64'(master_read), 64'd0);
    chk("rst_master_write", 64'(master_write), 64'd0);
    chk("rst_master_address", 64'(master_address), 64'd0);
    chk("rst_master_writedata", 64'(master_writedata), 64'd0);
    chk("rst_r0_readdata", 64'(r0_readdata), 64'd0);
    chk("rst_r1_readdata", 64'(r1_readdata), 64'd0);
    chk("rst_pending", 64'(pending_count), 64'd0);
    chk("rst_rsp_error", 64'(rsp_error), 64'd0);
    expect_grant(-1);

    // Both requesters read continuously: grants alternate from r0, data routed by tag
    r0_address = 26'h100; r1_address = 26'h200;
    r0_read = 1'b1; r1_read = 1'b1;
    auto_ret = 1;
    for (int g = 0; g < 8; g++) begin
      expect_grant(g % 2);
      step();
      expect_grant(-1);
      chk("rr_master_read", 64'(master_read), 64'd1);
      chk("rr_master_address", 64'(master_address), (g % 2 == 0) ? 64'h100 : 64'h200);
      step();
    end
    r0_read = 1'b0; r1_read = 1'b0;
    for (int i = 0; i < 6; i++) step();
    auto_ret = 0;
    chk("rr_r0_words", 64'(rx0), 64'd4);
    chk("rr_r1_words", 64'(rx1), 64'd4);
    chk("rr_pending_drained", 64'(pending_count), 64'd0);
    chk("rr_rsp_error", 64'(rsp_error), 64'd0);

    // r0 single write, no stall
    r0_address = 26'h8; r0_writedata = 32'hDEADBEEF; r0_write = 1'b1;
    expect_grant(0);
    step();
    r0_write = 1'b0;
    chk("wr_c1_write", 64'(master_write), 64'd1);
    chk("wr_c1_read", 64'(master_read), 64'd0);
    chk("wr_c1_address", 64'(master_address), 64'h8);
    chk("wr_c1_writedata", 64'(master_writedata), 64'hDEADBEEF);
    expect_grant(-1);
    step();
    chk("wr_c2_write", 64'(master_write), 64'd0);
    chk("wr_pending", 64'(pending_count), 64'd0);

    // r1 write stalled 5 cycles while r0 also wants the bus
    r1_address = 26'h123; r1_writedata = 32'hCAFEF00D; r1_write = 1'b1;
    r0_address = 26'h44;  r0_writedata = 32'h55;       r0_write = 1'b1;
    master_waitrequest = 1'b1;
    expect_grant(1);
    step();
    r1_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_grant(-1);
      chk("stall_write", 64'(master_write), 64'd1);
      chk("stall_address", 64'(master_address), 64'h123);
      chk("stall_writedata", 64'(master_writedata), 64'hCAFEF00D);
      step();
    end
    master_waitrequest = 1'b0;
    expect_grant(-1);
    chk("stall_c6_write", 64'(master_write), 64'd1);
    step();
    chk("stall_c7_write", 64'(master_write), 64'd0);
    expect_grant(0);
    step();
    r0_write = 1'b0;
    chk("stall_r0_address", 64'(master_address), 64'h44);
    step();

    // Four outstanding reads fill the tag FIFO
    r0_address = 26'h300; r0_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_grant(0);
      step();
      step();
    end
    chk("full_pending", 64'(pending_count), 64'd4);
    expect_grant(-1);
    step();
    expect_grant(-1);
    r1_address = 26'h400; r1_writedata = 32'h77; r1_write = 1'b1;
    expect_grant(1);
    step();
    r1_write = 1'b0;
    chk("full_write_issued", 64'(master_write), 64'd1);
    step();
    expect_grant(-1);
    chk("full_pending_after_write", 64'(pending_count), 64'd4);
    master_readdata = 32'hABCD0001; master_readdatavalid = 1'b1;
    expect_grant(-1);
    step();
    chk("full_pending_3", 64'(pending_count), 64'd3);
    expect_grant(0);
    step();
    r0_read = 1'b0;
    step();
    chk("full_pending_refill", 64'(pending_count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      master_readdata = 32'hABCD0002 + 32'(i); master_readdatavalid = 1'b1;
      step();
    end
    chk("full_pending_drained", 64'(pending_count), 64'd0);
    chk("full_rsp_error", 64'(rsp_error), 64'd0);

    // Stray response with nothing pending
    master_readdata = 32'hBAD0BAD0; master_readdatavalid = 1'b1;
    step();
    chk("stray_rsp_error", 64'(rsp_error), 64'd1);
    chk("stray_pending", 64'(pending_count), 64'd0);
    step();
    step();
    chk("stray_rsp_sticky", 64'(rsp_error), 64'd1);

    // Reset with two reads pending and a stalled read on the bus
    r0_address = 26'h500; r0_read = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_grant(0);
      step();
      step();
    end
    master_waitrequest = 1'b1;
    expect_grant(0);
    step();
    r0_read = 1'b0;
    chk("mid_master_read", 64'(master_read), 64'd1);
    chk("mid_pending", 64'(pending_count), 64'd2);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    master_waitrequest = 1'b0;
    chk("rst2_master_read", 64'(master_read), 64'd0);
    chk("rst2_pending", 64'(pending_count), 64'd0);
    chk("rst2_rsp_error", 64'(rsp_error), 64'd0);
    chk("rst2_r0_readdata", 64'(r0_readdata), 64'd0);
    r0_address = 26'h600; r0_write = 1'b1;
    r1_address = 26'h700; r1_write = 1'b1;
    expect_grant(0);
    step();
    r0_write = 1'b0; r1_write = 1'b0;
    chk("rst2_tie_address", 64'(master_address), 64'h600);
    step();
    step();
    master_readdata = 32'h0; master_readdatavalid = 1'b1;
    step();
    chk("rst2_stray_error", 64'(rsp_error), 64'd1);
    chk("rst2_stray_pending", 64'(pending_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
